ahb_arbiter_rr: RTL and testbench



---
 rtl/ahb_arbiter_rr_if.sv | 24 ++
 rtl/ahb_arbiter_rr.sv | 102 ++++++++++
 tb/tb_ahb_arbiter_rr.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_rr_if.sv
// Arbiter-side AHB signal bundle: requests and muxed bus status in, grant/owner/lock out.
interface ahb_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [1:0]             HRESP;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [3:0]             HMASTER;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB arbiter with fixed-length burst protection, early-termination
// recovery, locked-transfer hold and an address-phase aligned HMASTER/HMASTLOCK.
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb_arbiter_rr_if.slave bus
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  typedef logic [IW-1:0] idx_t;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [1:0] R_OKAY   = 2'd0;
  localparam logic [1:0] R_RETRY  = 2'd2;
  localparam logic [1:0] R_SPLIT  = 2'd3;

  idx_t                   grant_idx, ptr, rr_idx;
  logic                   rr_hit;
  logic [IW:0]            sum;
  logic [4:0]             cnt, cnt_nxt, burst_len;
  logic [3:0]             hmaster_q;
  logic                   mastlock_q;
  logic                   lock_hold, arb_ok, grant_upd;
  logic [NUM_MASTERS-1:0] grant_oh;

  always_comb begin
    burst_len = 5'd0;
    case (bus.HBURST)
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      3'd6, 3'd7: burst_len = 5'd16;
      default:    burst_len = 5'd0;
    endcase
  end

  // Beats remaining after this cycle; an error-class response abandons the burst.
  always_comb begin
    cnt_nxt = cnt;
    if (bus.HREADY) begin
      case (bus.HTRANS)
        T_NONSEQ: cnt_nxt = (burst_len != 5'd0) ? burst_len - 5'd1 : 5'd0;
        T_SEQ:    if (cnt != 5'd0) cnt_nxt = cnt - 5'd1;
        T_IDLE:   cnt_nxt = 5'd0;
        default:  cnt_nxt = cnt;
      endcase
    end
    if (bus.HRESP != R_OKAY) cnt_nxt = 5'd0;
  end

  assign arb_ok    = (cnt_nxt == 5'd0);
  assign lock_hold = bus.HLOCK[grant_idx] &&
                     !(bus.HRESP == R_RETRY || bus.HRESP == R_SPLIT);
  assign grant_upd = bus.HREADY && arb_ok && !lock_hold;

  // Descending scan so the smallest offset from the pointer wins; pointer itself is last.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = idx_t'(DEFAULT_MASTER);
    sum    = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_MASTERS)) sum = sum - (IW+1)'(NUM_MASTERS);
      if (bus.HBUSREQ[sum[IW-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_idx  <= idx_t'(DEFAULT_MASTER);
      ptr        <= idx_t'(DEFAULT_MASTER);
      cnt        <= 5'd0;
      hmaster_q  <= 4'(DEFAULT_MASTER);
      mastlock_q <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (bus.HREADY) begin
        hmaster_q  <= 4'(grant_idx);
        mastlock_q <= bus.HLOCK[grant_idx];
      end
      if (grant_upd) begin
        grant_idx <= rr_idx;
        if (rr_hit) ptr <= rr_idx;
      end
    end
  end

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  assign bus.HGRANT    = grant_oh;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed bench for ahb_arbiter_rr: 4-master instance plus 2- and 16-master instances.
module tb_ahb_arbiter_rr;
  logic HCLK = 1'b0;
  logic HRESET;
  int   checks = 0;
  int   errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_arbiter_rr_if #(.NUM_MASTERS(4))  bus4 ();
  ahb_arbiter_rr_if #(.NUM_MASTERS(2))  bus2 ();
  ahb_arbiter_rr_if #(.NUM_MASTERS(16)) bus16 ();

  ahb_arbiter_rr #(.NUM_MASTERS(4),  .DEFAULT_MASTER(0)) u4  (.HCLK(HCLK), .HRESET(HRESET), .bus(bus4));
  ahb_arbiter_rr #(.NUM_MASTERS(2),  .DEFAULT_MASTER(0)) u2  (.HCLK(HCLK), .HRESET(HRESET), .bus(bus2));
  ahb_arbiter_rr #(.NUM_MASTERS(16), .DEFAULT_MASTER(0)) u16 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus16));

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_all();
    bus4.HBUSREQ  = '0; bus4.HLOCK  = '0; bus4.HTRANS  = 2'd0; bus4.HBURST  = 3'd0;
    bus4.HREADY   = 1'b1; bus4.HRESP = 2'd0;
    bus2.HBUSREQ  = '0; bus2.HLOCK  = '0; bus2.HTRANS  = 2'd0; bus2.HBURST  = 3'd0;
    bus2.HREADY   = 1'b1; bus2.HRESP = 2'd0;
    bus16.HBUSREQ = '0; bus16.HLOCK = '0; bus16.HTRANS = 2'd0; bus16.HBURST = 3'd0;
    bus16.HREADY  = 1'b1; bus16.HRESP = 2'd0;
  endtask

  task automatic do_reset();
    idle_all();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    bus4.HBUSREQ = 4'b1111;
    HRESET = 1'b1;
    tick();
    tick();
    checks++; if (bus4.HGRANT !== 4'b0001) begin errors++; $display("FAIL rst_grant got %b exp %b", bus4.HGRANT, 4'b0001); end
    checks++; if (bus4.HMASTER !== 4'd0) begin errors++; $display("FAIL rst_hmaster got %0d exp 0", bus4.HMASTER); end
    checks++; if (bus4.HMASTLOCK !== 1'b0) begin errors++; $display("FAIL rst_mastlock got %b exp 0", bus4.HMASTLOCK); end
    checks++; if (bus16.HGRANT !== 16'h0001) begin errors++; $display("FAIL rst_grant16 got %h exp 0001", bus16.HGRANT); end
    HRESET = 1'b0;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0010) begin errors++; $display("FAIL rst_first_grant got %b exp %b", bus4.HGRANT, 4'b0010); end
    checks++; if (bus4.HMASTER !== 4'd0) begin errors++; $display("FAIL rst_first_hmaster got %0d exp 0", bus4.HMASTER); end
  endtask

  task automatic test_round_robin();
    int         exp_g [5] = '{1, 2, 3, 0, 1};
    int         exp_m [5] = '{0, 1, 2, 3, 0};
    logic [3:0] eg;
    do_reset();
    bus4.HBUSREQ = 4'b1111;
    bus4.HTRANS  = 2'd2;
    bus4.HBURST  = 3'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      eg = 4'b0001 << exp_g[i];
      checks++; if (bus4.HGRANT !== eg) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, bus4.HGRANT, eg); end
      checks++; if (bus4.HMASTER !== 4'(exp_m[i])) begin errors++; $display("FAIL rr_hmaster[%0d] got %0d exp %0d", i, bus4.HMASTER, exp_m[i]); end
    end
  endtask

  task automatic test_incr8();
    logic [1:0] tr [13] = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    logic       rd [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] eg;
    do_reset();
    bus4.HBUSREQ = 4'b0100;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0100) begin errors++; $display("FAIL incr8_setup got %b exp %b", bus4.HGRANT, 4'b0100); end
    bus4.HBUSREQ = 4'b1011;
    bus4.HBURST  = 3'd5;
    for (int i = 0; i < 13; i++) begin
      bus4.HTRANS = tr[i];
      bus4.HREADY = rd[i];
      tick();
      eg = (i == 12) ? 4'b1000 : 4'b0100;
      checks++; if (bus4.HGRANT !== eg) begin errors++; $display("FAIL incr8_grant[%0d] got %b exp %b", i, bus4.HGRANT, eg); end
    end
    checks++; if (bus4.HMASTER !== 4'd2) begin errors++; $display("FAIL incr8_hmaster got %0d exp 2", bus4.HMASTER); end
    bus4.HTRANS = 2'd0;
    bus4.HREADY = 1'b1;
  endtask

  task automatic test_early_term();
    do_reset();
    bus4.HBUSREQ = 4'b0010;
    tick();
    bus4.HBUSREQ = 4'b1111;
    bus4.HBURST  = 3'd3;
    bus4.HTRANS  = 2'd2;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0010) begin errors++; $display("FAIL et_beat1 got %b exp %b", bus4.HGRANT, 4'b0010); end
    bus4.HTRANS = 2'd3;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0010) begin errors++; $display("FAIL et_beat2 got %b exp %b", bus4.HGRANT, 4'b0010); end
    bus4.HREADY = 1'b0;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0010) begin errors++; $display("FAIL et_wait got %b exp %b", bus4.HGRANT, 4'b0010); end
    bus4.HRESP = 2'd2;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0010) begin errors++; $display("FAIL et_retry_hold got %b exp %b", bus4.HGRANT, 4'b0010); end
    bus4.HRESP  = 2'd0;
    bus4.HREADY = 1'b1;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0100) begin errors++; $display("FAIL et_regrant got %b exp %b", bus4.HGRANT, 4'b0100); end
    bus4.HTRANS = 2'd0;
  endtask

  task automatic test_lock();
    do_reset();
    bus4.HBUSREQ = 4'b1000;
    tick();
    checks++; if (bus4.HGRANT !== 4'b1000) begin errors++; $display("FAIL lock_setup got %b exp %b", bus4.HGRANT, 4'b1000); end
    checks++; if (bus4.HMASTLOCK !== 1'b0) begin errors++; $display("FAIL lock_first_mastlock got %b exp 0", bus4.HMASTLOCK); end
    bus4.HLOCK   = 4'b1000;
    bus4.HBUSREQ = 4'b1111;
    bus4.HTRANS  = 2'd2;
    bus4.HBURST  = 3'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus4.HGRANT !== 4'b1000) begin errors++; $display("FAIL lock_grant[%0d] got %b exp %b", i, bus4.HGRANT, 4'b1000); end
      checks++; if (bus4.HMASTLOCK !== 1'b1) begin errors++; $display("FAIL lock_mastlock[%0d] got %b exp 1", i, bus4.HMASTLOCK); end
    end
    checks++; if (bus4.HMASTER !== 4'd3) begin errors++; $display("FAIL lock_hmaster got %0d exp 3", bus4.HMASTER); end
    bus4.HLOCK  = 4'b0000;
    bus4.HTRANS = 2'd0;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0001) begin errors++; $display("FAIL lock_release got %b exp %b", bus4.HGRANT, 4'b0001); end
    checks++; if (bus4.HMASTLOCK !== 1'b0) begin errors++; $display("FAIL lock_release_mastlock got %b exp 0", bus4.HMASTLOCK); end
    // A SPLIT response overrides the owner's lock for that cycle.
    bus4.HLOCK  = 4'b0001;
    bus4.HTRANS = 2'd2;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0001) begin errors++; $display("FAIL lock0_hold got %b exp %b", bus4.HGRANT, 4'b0001); end
    bus4.HRESP = 2'd3;
    tick();
    checks++; if (bus4.HGRANT !== 4'b0010) begin errors++; $display("FAIL split_unlock got %b exp %b", bus4.HGRANT, 4'b0010); end
    bus4.HRESP  = 2'd0;
    bus4.HLOCK  = 4'b0000;
    bus4.HTRANS = 2'd0;
  endtask

  task automatic test_idle();
    do_reset();
    bus4.HBUSREQ = 4'b0100;
    tick();
    bus4.HBUSREQ = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus4.HGRANT !== 4'b0001) begin errors++; $display("FAIL idle_grant[%0d] got %b exp %b", i, bus4.HGRANT, 4'b0001); end
    end
    bus4.HBUSREQ = 4'b1111;
    tick();
    checks++; if (bus4.HGRANT !== 4'b1000) begin errors++; $display("FAIL idle_ptr_kept got %b exp %b", bus4.HGRANT, 4'b1000); end
    bus4.HBUSREQ = 4'b0000;

    bus16.HBUSREQ = 16'h8000;
    tick();
    checks++; if (bus16.HGRANT !== 16'h8000) begin errors++; $display("FAIL n16_grant15 got %h exp 8000", bus16.HGRANT); end
    bus16.HBUSREQ = 16'h8001;
    tick();
    checks++; if (bus16.HGRANT !== 16'h0001) begin errors++; $display("FAIL n16_wrap got %h exp 0001", bus16.HGRANT); end
    checks++; if (bus16.HMASTER !== 4'd15) begin errors++; $display("FAIL n16_hmaster got %0d exp 15", bus16.HMASTER); end
    bus16.HBUSREQ = 16'h0000;
    tick();
    checks++; if (bus16.HGRANT !== 16'h0001) begin errors++; $display("FAIL n16_idle got %h exp 0001", bus16.HGRANT); end
    bus16.HBUSREQ = 16'h8001;
    tick();
    checks++; if (bus16.HGRANT !== 16'h8000) begin errors++; $display("FAIL n16_ptr got %h exp 8000", bus16.HGRANT); end
    bus16.HBUSREQ = 16'h0000;

    bus2.HBUSREQ = 2'b11;
    tick();
    checks++; if (bus2.HGRANT !== 2'b10) begin errors++; $display("FAIL n2_g1 got %b exp 10", bus2.HGRANT); end
    tick();
    checks++; if (bus2.HGRANT !== 2'b01) begin errors++; $display("FAIL n2_g0 got %b exp 01", bus2.HGRANT); end
    checks++; if (bus2.HMASTER !== 4'd1) begin errors++; $display("FAIL n2_hmaster got %0d exp 1", bus2.HMASTER); end
    tick();
    checks++; if (bus2.HGRANT !== 2'b10) begin errors++; $display("FAIL n2_g1b got %b exp 10", bus2.HGRANT); end
    bus2.HBUSREQ = 2'b00;
    tick();
    checks++; if (bus2.HGRANT !== 2'b01) begin errors++; $display("FAIL n2_idle got %b exp 01", bus2.HGRANT); end
  endtask

  initial begin
    HRESET = 1'b1;
    idle_all();
    test_reset();
    test_round_robin();
    test_incr8();
    test_early_term();
    test_lock();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
